// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between p_num_req framed byte sources.
// Optional mid-frame stall timeout is compiled in with `define UART_TX_ARBITER_TIMEOUT_EN.
module uart_tx_arbiter #(
    parameter int p_num_req = 4,
    parameter int p_timeout = 65535
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [p_num_req-1:0]     i_req_valid,
    input  logic [8*p_num_req-1:0]   i_req_data,
    input  logic [p_num_req-1:0]     i_req_last,
    output logic [p_num_req-1:0]     o_req_ready,
    output logic [p_num_req-1:0]     o_grant,
    output logic                     o_tx_start,
    output logic [7:0]               o_tx_data,
    input  logic                     i_tx_done,
    output logic                     o_busy,
    output logic                     o_timeout
);

    localparam int IW = (p_num_req > 1) ? $clog2(p_num_req) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_WAIT
    } state_t;

    if (p_num_req < 2 || p_num_req > 8 || p_timeout < 1) begin : g_param_check
        $error("uart_tx_arbiter: p_num_req must be 2..8 and p_timeout at least 1");
    end

    state_t                 state;
    state_t                 state_nxt;
    logic [p_num_req-1:0]   grant;
    logic [p_num_req-1:0]   grant_nxt;
    logic [IW-1:0]          rr;
    logic [IW-1:0]          rr_nxt;
    logic [IW-1:0]          owner;
    logic [IW-1:0]          owner_nxt;
    logic [IW-1:0]          owner_inc;
    logic [7:0]             tx_data;
    logic [7:0]             data_nxt;
    logic                   last_q;
    logic                   last_nxt;
    logic                   sel_found;
    logic [IW-1:0]          sel_idx;
    logic                   owner_valid;
    logic [7:0]             owner_data;
    logic                   owner_last;

`ifdef UART_TX_ARBITER_TIMEOUT_EN
    localparam int CW = $clog2(p_timeout + 1);
    logic [CW-1:0]          cnt;
    logic [CW-1:0]          cnt_nxt;
    logic                   timeout_q;
    logic                   timeout_nxt;
`endif

    assign owner_valid = i_req_valid[owner];
    assign owner_data  = i_req_data[{owner, 3'b000} +: 8];
    assign owner_last  = i_req_last[owner];
    assign owner_inc   = (owner == IW'(p_num_req - 1)) ? '0 : owner + 1'b1;

    // First pass looks at or above the pointer, second pass wraps to the low indices.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int j = 0; j < p_num_req; j++) begin
            if (!sel_found && i_req_valid[j] && (IW'(j) >= rr)) begin
                sel_found = 1'b1;
                sel_idx   = IW'(j);
            end
        end
        for (int j = 0; j < p_num_req; j++) begin
            if (!sel_found && i_req_valid[j]) begin
                sel_found = 1'b1;
                sel_idx   = IW'(j);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        rr_nxt    = rr;
        owner_nxt = owner;
        data_nxt  = tx_data;
        last_nxt  = last_q;
`ifdef UART_TX_ARBITER_TIMEOUT_EN
        cnt_nxt     = cnt;
        timeout_nxt = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (sel_found) begin
                    grant_nxt = p_num_req'(1) << sel_idx;
                    owner_nxt = sel_idx;
                    state_nxt = ST_LOAD;
`ifdef UART_TX_ARBITER_TIMEOUT_EN
                    cnt_nxt   = '0;
`endif
                end
            end
            ST_LOAD: begin
                if (owner_valid) begin
                    data_nxt  = owner_data;
                    last_nxt  = owner_last;
                    state_nxt = ST_START;
`ifdef UART_TX_ARBITER_TIMEOUT_EN
                    cnt_nxt   = '0;
                end else if (cnt == CW'(p_timeout - 1)) begin
                    timeout_nxt = 1'b1;
                    grant_nxt   = '0;
                    rr_nxt      = owner_inc;
                    state_nxt   = ST_IDLE;
                    cnt_nxt     = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
`endif
                end
            end
            ST_START: begin
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (i_tx_done) begin
                    if (last_q) begin
                        grant_nxt = '0;
                        rr_nxt    = owner_inc;
                        state_nxt = ST_IDLE;
                    end else begin
                        state_nxt = ST_LOAD;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                grant_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= ST_IDLE;
            grant   <= '0;
            rr      <= '0;
            owner   <= '0;
            tx_data <= 8'h00;
            last_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            grant   <= grant_nxt;
            rr      <= rr_nxt;
            owner   <= owner_nxt;
            tx_data <= data_nxt;
            last_q  <= last_nxt;
        end
    end

`ifdef UART_TX_ARBITER_TIMEOUT_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt       <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt       <= cnt_nxt;
            timeout_q <= timeout_nxt;
        end
    end

    assign o_timeout = timeout_q;
`else
    assign o_timeout = 1'b0;
`endif

    assign o_req_ready = (state == ST_LOAD) ? grant : '0;
    assign o_grant     = grant;
    assign o_tx_start  = (state == ST_START);
    assign o_tx_data   = tx_data;
    assign o_busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus randomized frames
// checked against a frame-level round-robin reference model.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int TO = 16;

    logic             i_clk = 1'b0;
    logic             i_rst;
    logic [N-1:0]     i_req_valid;
    logic [8*N-1:0]   i_req_data;
    logic [N-1:0]     i_req_last;
    logic [N-1:0]     o_req_ready;
    logic [N-1:0]     o_grant;
    logic             o_tx_start;
    logic [7:0]       o_tx_data;
    logic             i_tx_done;
    logic             o_busy;
    logic             o_timeout;

    int total = 0;
    int bad   = 0;

    logic [8:0]  src_mem [N][64];
    int          head [N];
    int          tail [N];
    bit          mid [N];
    int          exp_owner [$];
    logic [7:0]  exp_byte [$];
    int          tx_cnt;

    uart_tx_arbiter #(.p_num_req(N), .p_timeout(TO)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_req_valid (i_req_valid),
        .i_req_data  (i_req_data),
        .i_req_last  (i_req_last),
        .o_req_ready (o_req_ready),
        .o_grant     (o_grant),
        .o_tx_start  (o_tx_start),
        .o_tx_data   (o_tx_data),
        .i_tx_done   (i_tx_done),
        .o_busy      (o_busy),
        .o_timeout   (o_timeout)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic clear_inputs();
        i_req_valid = '0;
        i_req_data  = '0;
        i_req_last  = '0;
        i_tx_done   = 1'b0;
    endtask

    task automatic clear_sources();
        for (int k = 0; k < N; k++) begin
            head[k] = 0;
            tail[k] = 0;
            mid[k]  = 1'b0;
        end
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        clear_inputs();
        clear_sources();
        step();
        step();
        i_rst = 1'b0;
    endtask

    task automatic push_byte(input int k, input logic [7:0] b, input logic last);
        src_mem[k][tail[k]] = {last, b};
        tail[k]++;
    endtask

    function automatic bit sources_empty();
        for (int k = 0; k < N; k++)
            if (head[k] < tail[k]) return 1'b0;
        return 1'b1;
    endfunction

    // Frame-level model: whole frames leave in round-robin order starting from requester 0.
    task automatic build_expected();
        int p [N];
        int rr;
        int sel;
        int k;
        logic [8:0] e;
        exp_owner.delete();
        exp_byte.delete();
        for (int i = 0; i < N; i++) p[i] = head[i];
        rr = 0;
        while (1) begin
            sel = -1;
            for (int i = 0; i < N; i++) begin
                k = (rr + i) % N;
                if (sel < 0 && p[k] < tail[k]) sel = k;
            end
            if (sel < 0) break;
            do begin
                e = src_mem[sel][p[sel]];
                p[sel]++;
                exp_owner.push_back(sel);
                exp_byte.push_back(e[7:0]);
            end while (!e[8] && p[sel] < tail[sel]);
            rr = (sel + 1) % N;
        end
    endtask

    task automatic drive(input bit stall_en);
        logic [8:0] e;
        for (int k = 0; k < N; k++) begin
            if (head[k] < tail[k]) begin
                e = src_mem[k][head[k]];
                i_req_valid[k]       = !(stall_en && mid[k] && ($urandom_range(0, 2) == 0));
                i_req_data[8*k +: 8] = e[7:0];
                i_req_last[k]        = e[8];
            end else begin
                i_req_valid[k]       = 1'b0;
                i_req_data[8*k +: 8] = 8'h00;
                i_req_last[k]        = 1'b0;
            end
        end
    endtask

    task automatic tick();
        logic [N-1:0] acc;
        logic [8:0]   e;
        acc = i_req_valid & o_req_ready;
        step();
        for (int k = 0; k < N; k++) begin
            if (acc[k] && head[k] < tail[k]) begin
                e = src_mem[k][head[k]];
                mid[k] = !e[8];
                head[k]++;
            end
        end
    endtask

    task automatic run_engine(input int budget, input bit stall_en);
        int cyc;
        int inv_bad;
        int owner;
        logic [7:0] b;
        cyc     = 0;
        inv_bad = 0;
        tx_cnt  = 0;
        i_tx_done = 1'b0;
        build_expected();
        drive(stall_en);
        while (cyc < budget &&
               !(exp_owner.size() == 0 && sources_empty() && !o_busy && tx_cnt == 0)) begin
            tick();
            cyc++;
            i_tx_done = 1'b0;
            if (tx_cnt > 0) begin
                tx_cnt--;
                if (tx_cnt == 0) i_tx_done = 1'b1;
            end
            if (o_tx_start) begin
                tx_cnt = $urandom_range(1, 4);
                total++;
                if (exp_owner.size() == 0) begin
                    bad++;
                    $display("[TB] FAIL engine_extra_start got data=%h grant=%b want no start", o_tx_data, o_grant);
                end else begin
                    owner = exp_owner.pop_front();
                    b     = exp_byte.pop_front();
                    if (o_tx_data !== b || o_grant !== (N'(1) << owner)) begin
                        bad++;
                        $display("[TB] FAIL engine_byte got data=%h grant=%b want data=%h owner=%0d",
                                 o_tx_data, o_grant, b, owner);
                    end
                end
            end
            if (!$onehot0(o_grant) || (o_req_ready & ~o_grant) != '0 || o_timeout !== 1'b0) inv_bad++;
            drive(stall_en);
        end
        total++;
        if (cyc >= budget) begin
            bad++;
            $display("[TB] FAIL engine_complete got %0d bytes outstanding want 0 within %0d cycles",
                     exp_owner.size(), budget);
        end
        total++;
        if (inv_bad != 0) begin
            bad++;
            $display("[TB] FAIL engine_invariants got %0d bad cycles want 0", inv_bad);
        end
        clear_inputs();
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        clear_inputs();
        clear_sources();
        i_req_valid = '1;
        i_tx_done   = 1'b1;
        step();
        total++; if (o_grant !== '0)     begin bad++; $display("[TB] FAIL reset_grant got=%b want=0", o_grant); end
        total++; if (o_req_ready !== '0) begin bad++; $display("[TB] FAIL reset_ready got=%b want=0", o_req_ready); end
        total++; if (o_tx_start !== 1'b0) begin bad++; $display("[TB] FAIL reset_start got=%b want=0", o_tx_start); end
        total++; if (o_tx_data !== 8'h00) begin bad++; $display("[TB] FAIL reset_data got=%h want=00", o_tx_data); end
        total++; if (o_busy !== 1'b0)    begin bad++; $display("[TB] FAIL reset_busy got=%b want=0", o_busy); end
        total++; if (o_timeout !== 1'b0) begin bad++; $display("[TB] FAIL reset_timeout got=%b want=0", o_timeout); end
        i_rst     = 1'b0;
        i_tx_done = 1'b0;
        step();
        total++; if (o_grant !== 4'b0001) begin bad++; $display("[TB] FAIL reset_first_arb got=%b want=0001", o_grant); end
        total++; if (o_req_ready !== 4'b0001) begin bad++; $display("[TB] FAIL reset_first_ready got=%b want=0001", o_req_ready); end
    endtask

    task automatic test_two_byte();
        do_reset();
        i_req_valid = 4'b0001;
        i_req_data[7:0] = 8'h41;
        i_req_last = 4'b0000;
        step();
        total++; if (o_grant !== 4'b0001 || o_req_ready !== 4'b0001 || o_tx_start !== 1'b0)
            begin bad++; $display("[TB] FAIL two_n1 got grant=%b ready=%b start=%b want 0001 0001 0", o_grant, o_req_ready, o_tx_start); end
        step();
        total++; if (o_tx_start !== 1'b1 || o_tx_data !== 8'h41)
            begin bad++; $display("[TB] FAIL two_n2 got start=%b data=%h want 1 41", o_tx_start, o_tx_data); end
        i_req_data[7:0] = 8'h42;
        i_req_last = 4'b0001;
        step();
        total++; if (o_tx_start !== 1'b0 || o_busy !== 1'b1)
            begin bad++; $display("[TB] FAIL two_wait got start=%b busy=%b want 0 1", o_tx_start, o_busy); end
        i_tx_done = 1'b1;
        step();
        i_tx_done = 1'b0;
        total++; if (o_req_ready !== 4'b0001 || o_grant !== 4'b0001)
            begin bad++; $display("[TB] FAIL two_reload got ready=%b grant=%b want 0001 0001", o_req_ready, o_grant); end
        step();
        total++; if (o_tx_start !== 1'b1 || o_tx_data !== 8'h42)
            begin bad++; $display("[TB] FAIL two_second got start=%b data=%h want 1 42", o_tx_start, o_tx_data); end
        i_req_valid = 4'b0000;
        step();
        total++; if (o_grant !== 4'b0001 || o_tx_data !== 8'h42)
            begin bad++; $display("[TB] FAIL two_hold got grant=%b data=%h want 0001 42", o_grant, o_tx_data); end
        i_tx_done = 1'b1;
        step();
        i_tx_done = 1'b0;
        total++; if (o_grant !== 4'b0000 || o_busy !== 1'b0)
            begin bad++; $display("[TB] FAIL two_release got grant=%b busy=%b want 0000 0", o_grant, o_busy); end
    endtask

    task automatic test_round_robin();
        do_reset();
        push_byte(0, 8'h10, 1'b1);
        push_byte(1, 8'h20, 1'b1);
        push_byte(2, 8'h30, 1'b1);
        push_byte(3, 8'h40, 1'b1);
        push_byte(0, 8'h50, 1'b1);
        run_engine(500, 1'b0);
    endtask

    task automatic test_random();
        int nf;
        int len;
        for (int it = 0; it < 6; it++) begin
            do_reset();
            for (int k = 0; k < N; k++) begin
                nf = $urandom_range(0, 2);
                for (int f = 0; f < nf; f++) begin
                    len = $urandom_range(1, 4);
                    for (int i = 0; i < len; i++)
                        push_byte(k, 8'($urandom), i == len - 1);
                end
            end
            if (sources_empty()) push_byte($urandom_range(0, N - 1), 8'($urandom), 1'b1);
            run_engine(3000, 1'b1);
        end
    endtask

    task automatic test_stall();
        int bad_cyc;
        do_reset();
        i_req_valid = 4'b0100;
        i_req_data[23:16] = 8'hAA;
        i_req_last = 4'b0000;
        step();
        total++; if (o_grant !== 4'b0100) begin bad++; $display("[TB] FAIL stall_grant got=%b want=0100", o_grant); end
        step();
        i_req_valid = 4'b0010;
        i_req_data[15:8] = 8'h77;
        i_req_last = 4'b0010;
        step();
        i_tx_done = 1'b1;
        step();
        i_tx_done = 1'b0;
        bad_cyc = 0;
`ifdef UART_TX_ARBITER_TIMEOUT_EN
        for (int c = 0; c < TO; c++) begin
            if (o_timeout !== 1'b0 || o_grant !== 4'b0100) bad_cyc++;
            step();
        end
        total++; if (bad_cyc != 0) begin bad++; $display("[TB] FAIL timeout_early got %0d bad cycles want 0", bad_cyc); end
        total++; if (o_timeout !== 1'b1 || o_grant !== 4'b0000)
            begin bad++; $display("[TB] FAIL timeout_pulse got to=%b grant=%b want 1 0000", o_timeout, o_grant); end
        step();
        total++; if (o_timeout !== 1'b0 || o_grant !== 4'b0010)
            begin bad++; $display("[TB] FAIL timeout_next got to=%b grant=%b want 0 0010", o_timeout, o_grant); end
`else
        for (int c = 0; c < 100; c++) begin
            if (o_grant !== 4'b0100 || o_tx_start !== 1'b0 || o_timeout !== 1'b0 || o_req_ready !== 4'b0100)
                bad_cyc++;
            step();
        end
        total++; if (bad_cyc != 0) begin bad++; $display("[TB] FAIL stall_hold got %0d bad cycles want 0", bad_cyc); end
        i_req_valid = 4'b0110;
        i_req_data[23:16] = 8'h55;
        i_req_last = 4'b0110;
        step();
        total++; if (o_tx_start !== 1'b1 || o_tx_data !== 8'h55 || o_grant !== 4'b0100)
            begin bad++; $display("[TB] FAIL stall_resume got start=%b data=%h grant=%b want 1 55 0100", o_tx_start, o_tx_data, o_grant); end
        i_req_valid = 4'b0010;
        step();
        i_tx_done = 1'b1;
        step();
        i_tx_done = 1'b0;
        total++; if (o_grant !== 4'b0000 || o_busy !== 1'b0)
            begin bad++; $display("[TB] FAIL stall_release got grant=%b busy=%b want 0000 0", o_grant, o_busy); end
        step();
        total++; if (o_grant !== 4'b0010) begin bad++; $display("[TB] FAIL stall_next got=%b want=0010", o_grant); end
`endif
    endtask

    task automatic test_reset_mid();
        int bad_cyc;
        do_reset();
        push_byte(1, 8'h99, 1'b1);
        run_engine(200, 1'b0);
        i_req_valid = 4'b0001;
        i_req_data[7:0] = 8'hA0;
        step();
        step();
        i_req_data[7:0] = 8'hA1;
        step();
        i_tx_done = 1'b1;
        step();
        i_tx_done = 1'b0;
        step();
        total++; if (o_tx_start !== 1'b1 || o_tx_data !== 8'hA1)
            begin bad++; $display("[TB] FAIL rmid_byte2 got start=%b data=%h want 1 a1", o_tx_start, o_tx_data); end
        step();
        i_rst = 1'b1;
        i_req_valid = 4'b0000;
        step();
        total++; if (o_grant !== '0 || o_req_ready !== '0 || o_tx_start !== 1'b0 || o_tx_data !== 8'h00 || o_busy !== 1'b0 || o_timeout !== 1'b0)
            begin bad++; $display("[TB] FAIL rmid_outputs got grant=%b ready=%b start=%b data=%h busy=%b to=%b want all 0",
                                  o_grant, o_req_ready, o_tx_start, o_tx_data, o_busy, o_timeout); end
        i_rst = 1'b0;
        bad_cyc = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (o_tx_start !== 1'b0 || o_busy !== 1'b0) bad_cyc++;
        end
        total++; if (bad_cyc != 0) begin bad++; $display("[TB] FAIL rmid_quiet got %0d bad cycles want 0", bad_cyc); end
        i_req_valid = 4'b1001;
        i_req_data[7:0]   = 8'hB0;
        i_req_data[31:24] = 8'hB3;
        i_req_last = 4'b1001;
        step();
        total++; if (o_grant !== 4'b0001) begin bad++; $display("[TB] FAIL rmid_rr got=%b want=0001", o_grant); end
        step();
        total++; if (o_tx_start !== 1'b1 || o_tx_data !== 8'hB0)
            begin bad++; $display("[TB] FAIL rmid_new got start=%b data=%h want 1 b0", o_tx_start, o_tx_data); end
    endtask

    task automatic test_spurious();
        int bad_cyc;
        do_reset();
        bad_cyc = 0;
        i_tx_done = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            if (o_busy !== 1'b0 || o_tx_start !== 1'b0) bad_cyc++;
        end
        total++; if (bad_cyc != 0) begin bad++; $display("[TB] FAIL spur_idle got %0d bad cycles want 0", bad_cyc); end
        i_tx_done = 1'b0;
        i_req_valid = 4'b0001;
        i_req_data[7:0] = 8'hC1;
        step();
        i_req_valid = 4'b0000;
        i_tx_done = 1'b1;
        bad_cyc = 0;
        for (int c = 0; c < 3; c++) begin
            step();
            if (o_req_ready !== 4'b0001 || o_tx_start !== 1'b0) bad_cyc++;
        end
        total++; if (bad_cyc != 0) begin bad++; $display("[TB] FAIL spur_load got %0d bad cycles want 0", bad_cyc); end
        i_tx_done = 1'b0;
        i_req_valid = 4'b0001;
        i_req_data[7:0] = 8'hC2;
        i_req_last = 4'b0001;
        step();
        total++; if (o_tx_start !== 1'b1 || o_tx_data !== 8'hC2)
            begin bad++; $display("[TB] FAIL spur_resume got start=%b data=%h want 1 c2", o_tx_start, o_tx_data); end
        i_req_valid = 4'b0000;
        step();
        i_tx_done = 1'b1;
        step();
        i_tx_done = 1'b0;
        total++; if (o_busy !== 1'b0 || o_grant !== 4'b0000)
            begin bad++; $display("[TB] FAIL spur_release got busy=%b grant=%b want 0 0000", o_busy, o_grant); end
    endtask

    initial begin
        i_rst = 1'b1;
        clear_inputs();
        clear_sources();
        test_reset();
        test_two_byte();
        test_round_robin();
        test_random();
        test_stall();
        test_reset_mid();
        test_spurious();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
